// File: rtl/window_reduce_datapath.sv
// Four-entry window collector with a reduce stage. Samples are steered into
// w0..w3 by the upstream selects; once every register has been loaded the
// window is reduced (sum, max, min or truncated average) one edge later and
// emitted with a single-cycle out_valid strobe.
module window_reduce_datapath (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] data_in,
  input  logic       select_m0,
  input  logic       select_m1,
  input  logic       select_m2,
  input  logic       select_m3,
  input  logic       select0,
  input  logic       select1,
  output logic [9:0] result,
  output logic       out_valid,
  output logic [7:0] win_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    CALC = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] mask, mask_next, sel_vec;
  logic [1:0] mode;
  logic [7:0] w0, w1, w2, w3;
  logic [7:0] wmax, wmin;
  logic [9:0] sum, reduced;
  logic       window_done;

  // Qualified selects, next mask and next state. A window can complete from
  // any state, including CALC, so back-to-back windows need no special path.
  always_comb begin
    sel_vec     = {select_m3, select_m2, select_m1, select_m0} & {4{in_valid}};
    mask_next   = mask | sel_vec;
    window_done = (mask_next == '1);
    state_next  = IDLE;
    if (window_done) begin
      state_next = CALC;
    end else if (mask_next != '0) begin
      state_next = FILL;
    end
  end

  // Reduce the current window contents according to the latched mode.
  always_comb begin
    sum  = 10'(w0) + 10'(w1) + 10'(w2) + 10'(w3);
    wmax = w0;
    wmin = w0;
    if (w1 > wmax) wmax = w1;
    if (w2 > wmax) wmax = w2;
    if (w3 > wmax) wmax = w3;
    if (w1 < wmin) wmin = w1;
    if (w2 < wmin) wmin = w2;
    if (w3 < wmin) wmin = w3;
    case (mode)
      2'b00:   reduced = sum;
      2'b01:   reduced = {2'b00, wmax};
      2'b10:   reduced = {2'b00, wmin};
      default: reduced = {2'b00, sum[9:2]};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Window registers, loaded mask and mode latch; the mask clears as the
  // window closes so loads on the following edge start a fresh window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      mode <= '0;
      w0   <= '0;
      w1   <= '0;
      w2   <= '0;
      w3   <= '0;
    end else begin
      mask <= window_done ? '0 : mask_next;
      if (window_done) mode <= {select1, select0};
      if (sel_vec[0]) w0 <= data_in;
      if (sel_vec[1]) w1 <= data_in;
      if (sel_vec[2]) w2 <= data_in;
      if (sel_vec[3]) w3 <= data_in;
    end
  end

  // Output stage: capture the reduction on the edge leaving CALC; the window
  // registers still hold the completed window at that point even if new loads
  // are presented on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
      win_count <= '0;
    end else begin
      out_valid <= (state == CALC);
      if (state == CALC) begin
        result    <= reduced;
        win_count <= win_count + 8'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_window_reduce_datapath.sv
// Self-checking bench for window_reduce_datapath: directed scenarios plus a
// randomized run, all checked against a behavioural window model.
module tb_window_reduce_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in;
  logic       select_m0, select_m1, select_m2, select_m3;
  logic       select0, select1;
  logic [9:0] result;
  logic       out_valid;
  logic [7:0] win_count;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int unsigned m_w[4];
  logic [3:0]  m_mask;
  bit          m_pending;
  logic [1:0]  m_mode;
  logic [9:0]  m_result;
  logic        m_valid;
  logic [7:0]  m_count;

  window_reduce_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .select_m0 (select_m0),
    .select_m1 (select_m1),
    .select_m2 (select_m2),
    .select_m3 (select_m3),
    .select0   (select0),
    .select1   (select1),
    .result    (result),
    .out_valid (out_valid),
    .win_count (win_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ref_reduce(input logic [1:0] md);
    int unsigned s = 0, mx = 0, mn = 255;
    for (int k = 0; k < 4; k++) begin
      s += m_w[k];
      if (m_w[k] > mx) mx = m_w[k];
      if (m_w[k] < mn) mn = m_w[k];
    end
    case (md)
      2'd0:    return 10'(s);
      2'd1:    return 10'(mx);
      2'd2:    return 10'(mn);
      default: return 10'(s / 4);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_w[k] = 0;
    m_mask = '0; m_pending = 0; m_mode = '0;
    m_result = '0; m_valid = 0; m_count = '0;
  endtask

  // One clock edge of the window rules, using the inputs currently driven.
  task automatic model_step();
    logic       nv;
    logic [3:0] s;
    nv = m_pending;
    if (m_pending) begin
      m_result = ref_reduce(m_mode);
      m_count  = m_count + 8'd1;
    end
    m_pending = 0;
    s = {select_m3, select_m2, select_m1, select_m0};
    for (int k = 0; k < 4; k++) begin
      if (in_valid && s[k]) begin
        m_w[k]    = data_in;
        m_mask[k] = 1'b1;
      end
    end
    if (m_mask == 4'hF) begin
      m_pending = 1;
      m_mode    = {select1, select0};
      m_mask    = '0;
    end
    m_valid = nv;
  endtask

  task automatic cycle(input logic iv, input logic [7:0] d,
                       input logic [3:0] sel, input logic [1:0] md);
    in_valid = iv;
    data_in  = d;
    {select_m3, select_m2, select_m1, select_m0} = sel;
    {select1, select0} = md;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; data_in = '0;
    {select_m3, select_m2, select_m1, select_m0} = '0;
    {select1, select0} = '0;
    #1 model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; data_in = '0;
    {select_m3, select_m2, select_m1, select_m0} = '0;
    {select1, select0} = '0;
    model_reset();
    @(posedge clk);
    #1;
    n_tests++; if (result !== 10'd0) begin n_fail++; $display("FAIL reset_result got=%0d exp=0", result); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (win_count !== 8'd0) begin n_fail++; $display("FAIL reset_win_count got=%0d exp=0", win_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_sum();
    do_reset();
    cycle(1, 8'd10, 4'b0001, 2'b00);
    cycle(1, 8'd20, 4'b0010, 2'b00);
    cycle(1, 8'd30, 4'b0100, 2'b00);
    cycle(1, 8'd40, 4'b1000, 2'b00);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sum_early_valid got=%b exp=0", out_valid); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sum_calc_busy got=%b exp=1", busy); end
    cycle(0, 8'd0, 4'b0000, 2'b00);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sum_valid got=%b exp=1", out_valid); end
    n_tests++; if (result !== 10'd100) begin n_fail++; $display("FAIL sum_result got=%0d exp=100", result); end
    n_tests++; if (win_count !== 8'd1) begin n_fail++; $display("FAIL sum_count got=%0d exp=1", win_count); end
    cycle(0, 8'd0, 4'b0000, 2'b00);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sum_pulse_width got=%b exp=0", out_valid); end
    n_tests++; if (result !== 10'd100) begin n_fail++; $display("FAIL sum_hold got=%0d exp=100", result); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sum_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_modes();
    logic [9:0] exp_v[4];
    exp_v[0] = 10'd552; exp_v[1] = 10'd255; exp_v[2] = 10'd7; exp_v[3] = 10'd138;
    for (int md = 1; md < 4; md++) begin
      cycle(1, 8'd200, 4'b0001, 2'(md + 1));
      cycle(1, 8'd7,   4'b0010, 2'b00);
      cycle(1, 8'd255, 4'b0100, 2'b00);
      cycle(1, 8'd90,  4'b1000, 2'(md));
      cycle(0, 8'd0, 4'b0000, 2'b00);
      n_tests++; if (out_valid !== 1'b1 || result !== exp_v[md])
        begin n_fail++; $display("FAIL mode%0d_result got=%0d/%b exp=%0d/1", md, result, out_valid, exp_v[md]); end
      n_tests++; if (win_count !== m_count)
        begin n_fail++; $display("FAIL mode%0d_count got=%0d exp=%0d", md, win_count, m_count); end
    end
  endtask

  task automatic test_simultaneous();
    cycle(1, 8'd50, 4'b1111, 2'b00);
    cycle(0, 8'd0, 4'b0000, 2'b00);
    n_tests++; if (out_valid !== 1'b1 || result !== 10'd200)
      begin n_fail++; $display("FAIL simul_result got=%0d/%b exp=200/1", result, out_valid); end
    cycle(1, 8'd5, 4'b0001, 2'b00);
    cycle(1, 8'd9, 4'b0001, 2'b00);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL overwrite_busy got=%b exp=1", busy); end
    cycle(1, 8'd1, 4'b0010, 2'b00);
    cycle(1, 8'd1, 4'b0100, 2'b00);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL overwrite_no_double got=%b exp=0", out_valid); end
    cycle(1, 8'd1, 4'b1000, 2'b00);
    cycle(0, 8'd0, 4'b0000, 2'b00);
    n_tests++; if (out_valid !== 1'b1 || result !== 10'd12)
      begin n_fail++; $display("FAIL overwrite_result got=%0d/%b exp=12/1", result, out_valid); end
  endtask

  task automatic test_gating();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 8'($urandom), 4'b1111, 2'($urandom));
      n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0)
        begin n_fail++; $display("FAIL gating_%0d got busy=%b valid=%b exp busy=0 valid=0", i, busy, out_valid); end
    end
    cycle(1, 8'd3, 4'b0001, 2'b00);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gating_load_busy got=%b exp=1", busy); end
    cycle(0, 8'd0, 4'b1110, 2'b00);
    cycle(1, 8'd4, 4'b1110, 2'b00);
    cycle(0, 8'd0, 4'b0000, 2'b00);
    n_tests++; if (out_valid !== 1'b1 || result !== 10'd15)
      begin n_fail++; $display("FAIL gating_result got=%0d/%b exp=15/1", result, out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1, 8'd1, 4'b0001, 2'b00);
    cycle(1, 8'd2, 4'b0010, 2'b00);
    cycle(1, 8'd3, 4'b0100, 2'b00);
    cycle(1, 8'd4, 4'b1000, 2'b00);
    cycle(1, 8'd100, 4'b1111, 2'b01);
    n_tests++; if (out_valid !== 1'b1 || result !== 10'd10)
      begin n_fail++; $display("FAIL b2b_first got=%0d/%b exp=10/1", result, out_valid); end
    cycle(1, 8'd5, 4'b0001, 2'b00);
    n_tests++; if (out_valid !== 1'b1 || result !== 10'd100)
      begin n_fail++; $display("FAIL b2b_second got=%0d/%b exp=100/1", result, out_valid); end
    n_tests++; if (win_count !== 8'd2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", win_count); end
    cycle(1, 8'd6, 4'b0010, 2'b00);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got=%b exp=0", out_valid); end
    cycle(1, 8'd7, 4'b0100, 2'b00);
    cycle(1, 8'd8, 4'b1000, 2'b11);
    cycle(0, 8'd0, 4'b0000, 2'b00);
    n_tests++; if (out_valid !== 1'b1 || result !== 10'd6 || win_count !== 8'd3)
      begin n_fail++; $display("FAIL b2b_third got=%0d/%b/%0d exp=6/1/3", result, out_valid, win_count); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 8'd9, 4'b0001, 2'b00);
    cycle(1, 8'd9, 4'b0010, 2'b00);
    cycle(1, 8'd9, 4'b0100, 2'b00);
    rst = 1'b1;
    #1 model_reset();
    n_tests++; if (result !== 10'd0 || out_valid !== 1'b0 || win_count !== 8'd0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL midreset_outputs got=%0d/%b/%0d/%b exp=0/0/0/0", result, out_valid, win_count, busy); end
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1, 8'd77, 4'b1000, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 8'd0, 4'b0000, 2'b00);
      n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1)
        begin n_fail++; $display("FAIL midreset_partial_%0d got valid=%b busy=%b exp valid=0 busy=1", i, out_valid, busy); end
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      if (i < 256) cycle(1, 8'(i), 4'b1111, 2'b00);
      else         cycle(0, 8'd0, 4'b0000, 2'b00);
      if (out_valid === 1'b1) pulses++;
      n_tests++; if (win_count !== m_count || out_valid !== m_valid || result !== m_result)
        begin n_fail++; $display("FAIL wrap_step%0d got=%0d/%b/%0d exp=%0d/%b/%0d", i, win_count, out_valid, result, m_count, m_valid, m_result); end
    end
    n_tests++; if (pulses != 256 || win_count !== 8'd0)
      begin n_fail++; $display("FAIL wrap_final got pulses=%0d count=%0d exp pulses=256 count=0", pulses, win_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom), 2'($urandom));
      n_tests++; if (out_valid !== m_valid || result !== m_result || win_count !== m_count ||
                     busy !== (m_pending || m_mask != 4'h0))
        begin n_fail++; $display("FAIL random_%0d got=%0d/%b/%0d/%b exp=%0d/%b/%0d/%b", i,
              result, out_valid, win_count, busy, m_result, m_valid, m_count, (m_pending || m_mask != 4'h0)); end
    end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_modes();
    test_simultaneous();
    test_gating();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
